// File: rtl/test_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : test_run_sequencer
//  Description : Test-mode sequencer for the single-cycle RISC datapath.
//                Streams a program image into instruction/data memory,
//                pulses clear, runs the core for a budget or until halt,
//                and captures OutR results into a readback FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_run_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RUN_W      = 16,
    parameter int CLR_CYCLES = 1,
    parameter int OUT_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_target,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [RUN_W-1:0]  run_budget,
    input  logic              halt_in,
    input  logic              outr_valid_in,
    input  logic [DATA_W-1:0] outr_in,
    input  logic              rearm,
    output logic              test_normal,
    output logic              ext_instr_we,
    output logic [ADDR_W-1:0] ext_instr_addr,
    output logic [DATA_W-1:0] ext_instr_data,
    output logic              ext_data_write_en,
    output logic [ADDR_W-1:0] ext_data_addr,
    output logic [DATA_W-1:0] ext_data_data,
    output logic              clr,
    output logic              core_run,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic [DATA_W-1:0] cap_data,
    output logic              cap_overflow,
    output logic              done,
    output logic              done_cause,
    output logic [RUN_W-1:0]  cycle_count
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [RUN_W-1:0]    budget_q, budget_d;
    logic [RUN_W-1:0]    cycle_count_q, cycle_count_d;
    logic                done_cause_q, done_cause_d;
    logic                ld_ready_q, ld_ready_d;
    logic                test_normal_q, test_normal_d;
    logic                clr_q, clr_d;
    logic                core_run_q, core_run_d;
    logic                done_q, done_d;
    logic                instr_we_q, instr_we_d;
    logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
    logic [DATA_W-1:0]   instr_data_q, instr_data_d;
    logic                data_we_q, data_we_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W-1:0]   data_data_q, data_data_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [OUT_DEPTH];
    logic [DATA_W-1:0]   mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic                cap_valid_q, cap_valid_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d;

    logic                accept, pop, full, push_req, push_ok;
    logic [RUN_W-1:0]    cc_inc;
    logic [CNT_W-1:0]    remaining;

    // Handshake qualifiers and saturating cycle increment
    always_comb begin
        accept   = ld_valid && ld_ready_q;
        pop      = cap_valid_q && cap_ready;
        full     = (fifo_cnt_q == CNT_W'(OUT_DEPTH));
        push_req = (state_q == ST_RUN) && outr_valid_in;
        push_ok  = push_req && (!full || pop);
        cc_inc   = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    end

    // Sequencer next-state, budget latch, cycle counter and exit cause
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        budget_d      = budget_q;
        cycle_count_d = cycle_count_q;
        done_cause_d  = done_cause_q;
        case (state_q)
            ST_LOAD: begin
                if (accept && ld_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                budget_d  = run_budget;
                clr_cnt_d = '0;
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: begin
                cycle_count_d = '0;
                done_cause_d  = 1'b0;
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) state_d = ST_RUN;
                else clr_cnt_d = clr_cnt_q + 1'b1;
            end
            ST_RUN: begin
                cycle_count_d = cc_inc;
                // Halt takes priority when it coincides with budget expiry
                if (halt_in) begin
                    state_d      = ST_DONE;
                    done_cause_d = 1'b0;
                end else if ((budget_q != '0) && (cc_inc == budget_q)) begin
                    state_d      = ST_DONE;
                    done_cause_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (rearm) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Registered outputs derived from the next state and load accepts
    always_comb begin
        ld_ready_d    = (state_d == ST_LOAD);
        test_normal_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        clr_d         = (state_d == ST_CLEAR);
        core_run_d    = (state_d == ST_RUN);
        done_d        = (state_d == ST_DONE);
        instr_we_d    = accept && !ld_target;
        data_we_d     = accept && ld_target;
        instr_addr_d  = instr_addr_q;
        instr_data_d  = instr_data_q;
        data_addr_d   = data_addr_q;
        data_data_d   = data_data_q;
        if (accept && !ld_target) begin
            instr_addr_d = ld_addr;
            instr_data_d = ld_data;
        end
        if (accept && ld_target) begin
            data_addr_d = ld_addr;
            data_data_d = ld_data;
        end
    end

    // Capture FIFO: storage, pointers, registered head and overflow flag
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = outr_in;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        cap_valid_d = (fifo_cnt_d != '0);
        remaining   = fifo_cnt_q - CNT_W'(pop);
        // Head is an older stored word if one survives the pop, else the new push
        if (remaining != '0)  cap_data_d = mem_q[rd_ptr_d];
        else if (push_ok)     cap_data_d = outr_in;
        else                  cap_data_d = cap_data_q;
        overflow_d = overflow_q;
        if (push_req && !push_ok)            overflow_d = 1'b1;
        if ((state_q == ST_DONE) && rearm)   overflow_d = 1'b0;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= ST_LOAD;
            clr_cnt_q     <= '0;
            budget_q      <= '0;
            cycle_count_q <= '0;
            done_cause_q  <= 1'b0;
            ld_ready_q    <= 1'b1;
            test_normal_q <= 1'b1;
            clr_q         <= 1'b0;
            core_run_q    <= 1'b0;
            done_q        <= 1'b0;
            instr_we_q    <= 1'b0;
            instr_addr_q  <= '0;
            instr_data_q  <= '0;
            data_we_q     <= 1'b0;
            data_addr_q   <= '0;
            data_data_q   <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            cap_valid_q   <= 1'b0;
            cap_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            budget_q      <= budget_d;
            cycle_count_q <= cycle_count_d;
            done_cause_q  <= done_cause_d;
            ld_ready_q    <= ld_ready_d;
            test_normal_q <= test_normal_d;
            clr_q         <= clr_d;
            core_run_q    <= core_run_d;
            done_q        <= done_d;
            instr_we_q    <= instr_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_data_q  <= instr_data_d;
            data_we_q     <= data_we_d;
            data_addr_q   <= data_addr_d;
            data_data_q   <= data_data_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            cap_valid_q   <= cap_valid_d;
            cap_data_q    <= cap_data_d;
        end
    end

    assign ld_ready          = ld_ready_q;
    assign test_normal       = test_normal_q;
    assign ext_instr_we      = instr_we_q;
    assign ext_instr_addr    = instr_addr_q;
    assign ext_instr_data    = instr_data_q;
    assign ext_data_write_en = data_we_q;
    assign ext_data_addr     = data_addr_q;
    assign ext_data_data     = data_data_q;
    assign clr               = clr_q;
    assign core_run          = core_run_q;
    assign cap_valid         = cap_valid_q;
    assign cap_data          = cap_data_q;
    assign cap_overflow      = overflow_q;
    assign done              = done_q;
    assign done_cause        = done_cause_q;
    assign cycle_count       = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_test_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_run_sequencer
//  Description : Directed self-checking bench for test_run_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_run_sequencer;

    logic        clk;
    logic        clr_n;
    logic        ld_valid, ld_ready, ld_target, ld_last;
    logic [15:0] ld_addr, ld_data, run_budget;
    logic        halt_in, outr_valid_in, rearm;
    logic [15:0] outr_in;
    logic        test_normal, ext_instr_we, ext_data_write_en;
    logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic        clr, core_run, cap_valid, cap_ready, cap_overflow, done, done_cause;
    logic [15:0] cap_data, cycle_count;

    int checks = 0;
    int errors = 0;

    test_run_sequencer #(
        .DATA_W(16), .ADDR_W(16), .RUN_W(16), .CLR_CYCLES(1), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .clr_n(clr_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_target(ld_target),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .run_budget(run_budget), .halt_in(halt_in),
        .outr_valid_in(outr_valid_in), .outr_in(outr_in), .rearm(rearm),
        .test_normal(test_normal),
        .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr),
        .ext_instr_data(ext_instr_data),
        .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr),
        .ext_data_data(ext_data_data),
        .clr(clr), .core_run(core_run),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
        .cap_overflow(cap_overflow), .done(done), .done_cause(done_cause),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_valid;
        logic        ld_target;
        logic [15:0] ld_addr;
        logic [15:0] ld_data;
        logic        ld_last;
        logic        rearm;
        logic        ld_ready;
        logic        test_normal;
        logic        iwe;
        logic [15:0] ia;
        logic [15:0] idat;
        logic        dwe;
        logic [15:0] da;
        logic [15:0] dd;
        logic        clr;
        logic        run;
        logic        done;
        logic        cause;
        logic [15:0] cc;
    } vec_t;

    vec_t tv [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Address/data only matter while their strobe is high
    function automatic logic [127:0] pack(
        input logic lr, input logic tn, input logic iwe, input logic [15:0] ia,
        input logic [15:0] idat, input logic dwe, input logic [15:0] da,
        input logic [15:0] dd, input logic c, input logic r, input logic d,
        input logic ca, input logic [15:0] cc);
        return {40'h0, lr, tn, iwe, (iwe ? ia : 16'h0), (iwe ? idat : 16'h0),
                dwe, (dwe ? da : 16'h0), (dwe ? dd : 16'h0), c, r, d, ca, cc};
    endfunction

    task automatic start_run(input logic [15:0] budget);
        run_budget = budget;
        ld_valid   = 1'b1;
        ld_target  = 1'b1;
        ld_addr    = 16'h0010;
        ld_data    = 16'h0055;
        ld_last    = 1'b1;
        step();
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        step();
        step();
    endtask

    task automatic do_rearm(input string name);
        rearm = 1'b1;
        step();
        rearm = 1'b0;
        check({name, "_ldready_done"}, {126'h0, ld_ready, done}, 128'h2);
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ld_valid tgt addr data last rearm | lr tn iwe ia idat dwe da dd clr run done cause cc
        tv[0]  = '{1,0,16'h0000,16'h1900,0,0, 1,1,1,16'h0000,16'h1900,0,16'h0,16'h0,   0,0,0,0,16'd0};
        tv[1]  = '{1,0,16'h0001,16'h8008,0,0, 1,1,1,16'h0001,16'h8008,0,16'h0,16'h0,   0,0,0,0,16'd0};
        tv[2]  = '{1,1,16'h0000,16'h1234,1,0, 0,1,0,16'h0,16'h0,1,16'h0000,16'h1234,   0,0,0,0,16'd0};
        tv[3]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         1,0,0,0,16'd0};
        tv[4]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,1,0,0,16'd0};
        tv[5]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,1,0,0,16'd1};
        tv[6]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,1,0,0,16'd2};
        tv[7]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,1,0,0,16'd3};
        tv[8]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,1,0,0,16'd4};
        tv[9]  = '{0,0,16'h0000,16'h0000,0,0, 0,0,0,16'h0,16'h0,0,16'h0,16'h0,         0,0,1,1,16'd5};
        tv[10] = '{0,0,16'h0000,16'h0000,0,1, 1,1,0,16'h0,16'h0,0,16'h0,16'h0,         0,0,0,1,16'd5};

        clr_n = 1'b0; ld_valid = 1'b0; ld_target = 1'b0; ld_addr = '0; ld_data = '0;
        ld_last = 1'b0; run_budget = '0; halt_in = 1'b0; outr_valid_in = 1'b0;
        outr_in = '0; rearm = 1'b0; cap_ready = 1'b0;

        // Reset state
        #12;
        check("rst_ready_tn_run_clr", {124'h0, ld_ready, test_normal, core_run, clr}, 128'hC);
        check("rst_strobes", {126'h0, ext_instr_we, ext_data_write_en}, 128'h0);
        check("rst_addr_data", {64'h0, ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data}, 128'h0);
        check("rst_cap", {110'h0, cap_valid, cap_overflow, cap_data}, 128'h0);
        check("rst_done_cc", {110'h0, done, done_cause, cycle_count}, 128'h0);
        clr_n = 1'b1;

        // Load image and run with budget 5
        run_budget = 16'd5;
        for (int i = 0; i < 11; i++) begin
            ld_valid  = tv[i].ld_valid;
            ld_target = tv[i].ld_target;
            ld_addr   = tv[i].ld_addr;
            ld_data   = tv[i].ld_data;
            ld_last   = tv[i].ld_last;
            rearm     = tv[i].rearm;
            step();
            check($sformatf("vec%0d", i),
                  pack(ld_ready, test_normal, ext_instr_we, ext_instr_addr, ext_instr_data,
                       ext_data_write_en, ext_data_addr, ext_data_data,
                       clr, core_run, done, done_cause, cycle_count),
                  pack(tv[i].ld_ready, tv[i].test_normal, tv[i].iwe, tv[i].ia, tv[i].idat,
                       tv[i].dwe, tv[i].da, tv[i].dd,
                       tv[i].clr, tv[i].run, tv[i].done, tv[i].cause, tv[i].cc));
        end
        ld_valid = 1'b0; rearm = 1'b0;

        // Unlimited budget, halt in RUN cycle 3
        start_run(16'd0);
        check("haltA_run1", {127'h0, core_run}, 128'h1);
        step(); step();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check("haltA_end", {108'h0, core_run, done, done_cause, 1'b0, cycle_count}, {108'h0, 4'b0100, 16'd3});
        do_rearm("haltA");

        // Budget 4 with halt in cycle 4: halt wins
        start_run(16'd4);
        step(); step(); step();
        check("haltB_run4", {112'h0, core_run, 15'h0}, {112'h0, 1'b1, 15'h0});
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check("haltB_end", {108'h0, core_run, done, done_cause, 1'b0, cycle_count}, {108'h0, 4'b0100, 16'd4});
        do_rearm("haltB");

        // Six captures into a depth-4 FIFO with no reads
        start_run(16'd0);
        for (int k = 1; k <= 6; k++) begin
            outr_valid_in = 1'b1;
            outr_in = 16'(k);
            step();
        end
        outr_valid_in = 1'b0;
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check("fifo_ovf_done", {125'h0, cap_overflow, done, cap_valid}, 128'h7);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fifo_rd%0d", k), {111'h0, cap_valid, cap_data}, {111'h0, 1'b1, 16'(k)});
            cap_ready = 1'b1;
            step();
            cap_ready = 1'b0;
        end
        check("fifo_empty", {127'h0, cap_valid}, 128'h0);
        do_rearm("fifo");
        check("fifo_ovf_cleared", {127'h0, cap_overflow}, 128'h0);

        // Asynchronous reset during RUN cycle 2
        start_run(16'd0);
        outr_valid_in = 1'b1;
        outr_in = 16'h00AB;
        step();
        outr_valid_in = 1'b0;
        check("areset_pre", {111'h0, cap_valid, cap_data}, {111'h0, 1'b1, 16'h00AB});
        #2;
        clr_n = 1'b0;
        #1;
        check("areset_ctl", {124'h0, core_run, test_normal, ld_ready, clr}, 128'h6);
        check("areset_fifo", {110'h0, cap_valid, cap_overflow, cap_data}, 128'h0);
        check("areset_done_cc", {110'h0, done, done_cause, cycle_count}, 128'h0);
        @(negedge clk);
        clr_n = 1'b1;
        step();
        check("areset_load", {125'h0, ld_ready, test_normal, core_run}, 128'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
